// File: rtl/saph_fpu_issuer.sv
// Core-side initiator of the saph_fpi FPU interface: credit-gated issue to a fixed-latency FPU,
// a tag/err delay line matched to that latency, and an in-order response FIFO.
module saph_fpu_issuer #(
  parameter int unsigned FPU_LATENCY = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_mode,
  input  logic [31:0]                  req_lhs,
  input  logic [31:0]                  req_rhs,
  input  logic [TAG_W-1:0]             req_tag,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_res,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic                         rsp_err,
  output logic                         fpu_d_trig,
  output logic [1:0]                   fpu_d_mode,
  output logic [31:0]                  fpu_d_lhs,
  output logic [31:0]                  fpu_d_rhs,
  input  logic                         fpu_d_ready,
  input  logic [31:0]                  fpu_q_res,
  input  logic [3:0]                   fpu_has_modes,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OW-1:0] DEPTH_C  = OW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  logic             issue;
  logic             req_err;
  logic             cap_valid;
  logic [TAG_W-1:0] cap_tag;
  logic             cap_err;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_ok;
  logic             ovf_err;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    count;
  logic [31:0]      mem_res [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic             mem_err [DEPTH];

  assign req_ready  = !rst && fpu_d_ready && (outstanding < DEPTH_C);
  assign issue      = req_valid && req_ready;
  assign req_err    = !fpu_has_modes[req_mode];
  assign fpu_d_trig = issue;
  assign fpu_d_mode = req_mode;
  assign fpu_d_lhs  = req_lhs;
  assign fpu_d_rhs  = req_rhs;

  generate
    if (FPU_LATENCY == 0) begin : g_nodelay
      assign cap_valid = issue;
      assign cap_tag   = req_tag;
      assign cap_err   = req_err;
    end else begin : g_delay
      logic [FPU_LATENCY-1:0] dl_valid;
      logic [FPU_LATENCY-1:0] dl_err;
      logic [TAG_W-1:0]       dl_tag [FPU_LATENCY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dl_valid <= '0;
          dl_err   <= '0;
          for (int unsigned i = 0; i < FPU_LATENCY; i++) dl_tag[i] <= '0;
        end else begin
          dl_valid[0] <= issue;
          dl_err[0]   <= req_err;
          dl_tag[0]   <= req_tag;
          for (int unsigned i = 1; i < FPU_LATENCY; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_err[i]   <= dl_err[i-1];
            dl_tag[i]   <= dl_tag[i-1];
          end
        end
      end

      assign cap_valid = dl_valid[FPU_LATENCY-1];
      assign cap_tag   = dl_tag[FPU_LATENCY-1];
      assign cap_err   = dl_err[FPU_LATENCY-1];
    end
  endgenerate

  assign push      = cap_valid;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign full      = (count == DEPTH_C);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign wr_ok     = push && (!full || pop);

  assign rsp_res = rsp_valid ? mem_res[rd_ptr] : '0;
  assign rsp_tag = rsp_valid ? mem_tag[rd_ptr] : '0;
  assign rsp_err = rsp_valid ? mem_err[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_res[wr_ptr] <= cap_err ? QNAN : fpu_q_res;
      mem_tag[wr_ptr] <= cap_tag;
      mem_err[wr_ptr] <= cap_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      ovf_err     <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (push && full && !pop) ovf_err <= 1'b1;
    end
  end

  a_no_ovf: assert property (@(posedge clk) !ovf_err);

endmodule

// File: tb/tb_saph_fpu_issuer.sv
// Bench for saph_fpu_issuer: fixed-latency FPU model plus a scoreboard of expected responses.
module tb_saph_fpu_issuer;

  localparam int LAT = 2;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_mode = '0;
  logic [31:0] req_lhs = '0;
  logic [31:0] req_rhs = '0;
  logic [3:0]  req_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        fpu_d_trig;
  logic [1:0]  fpu_d_mode;
  logic [31:0] fpu_d_lhs;
  logic [31:0] fpu_d_rhs;
  logic        fpu_d_ready = 1'b1;
  logic [31:0] fpu_q_res;
  logic [3:0]  fpu_has_modes = 4'hF;
  logic [2:0]  outstanding;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  saph_fpu_issuer #(.FPU_LATENCY(LAT), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_lhs(req_lhs), .req_rhs(req_rhs), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .fpu_d_trig(fpu_d_trig), .fpu_d_mode(fpu_d_mode), .fpu_d_lhs(fpu_d_lhs),
    .fpu_d_rhs(fpu_d_rhs), .fpu_d_ready(fpu_d_ready), .fpu_q_res(fpu_q_res),
    .fpu_has_modes(fpu_has_modes), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  // Known float results for the directed vectors, an arbitrary mix otherwise.
  function automatic logic [31:0] fpu_calc(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    if (m == 2'b00 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (m == 2'b01 && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, m};
  endfunction

  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fpu_d_trig ? fpu_calc(fpu_d_mode, fpu_d_lhs, fpu_d_rhs) : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fpu_q_res = pipe[LAT-1];

  always @(negedge clk) begin
    rsp_t e;
    if (req_valid) begin
      checks++;
      if (fpu_d_trig !== (req_valid && req_ready) || fpu_d_mode !== req_mode ||
          fpu_d_lhs !== req_lhs || fpu_d_rhs !== req_rhs) begin
        errors++;
        $display("FAIL fpu_d_passthrough trig=%b mode=%b lhs=%h rhs=%h expected trig=%b mode=%b lhs=%h rhs=%h",
                 fpu_d_trig, fpu_d_mode, fpu_d_lhs, fpu_d_rhs, req_valid && req_ready, req_mode, req_lhs, req_rhs);
      end
    end
    if (req_valid && req_ready) begin
      e.err = !fpu_has_modes[req_mode];
      e.res = e.err ? QNAN : fpu_calc(req_mode, req_lhs, req_rhs);
      e.tag = req_tag;
      sb.push_back(e);
    end
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got res=%h tag=%0d err=%b expected no response", rsp_res, rsp_tag, rsp_err);
      end else begin
        e = sb.pop_front();
        if ({rsp_res, rsp_tag, rsp_err} !== e) begin
          errors++;
          $display("FAIL rsp_data got res=%h tag=%0d err=%b expected res=%h tag=%0d err=%b",
                   rsp_res, rsp_tag, rsp_err, e.res, e.tag, e.err);
        end
      end
    end
  end

  task automatic drive_req(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    req_mode = m; req_lhs = a; req_rhs = b; req_tag = t; req_valid = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, req_ready, fpu_d_trig, outstanding, rsp_res, rsp_tag, rsp_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rsp_valid=%b req_ready=%b trig=%b outstanding=%0d res=%h tag=%0d err=%b expected all 0",
               rsp_valid, req_ready, fpu_d_trig, outstanding, rsp_res, rsp_tag, rsp_err);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || outstanding !== 3'd0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset req_ready=%b outstanding=%0d rsp_valid=%b expected 1 0 0", req_ready, outstanding, rsp_valid);
    end
  endtask

  task automatic test_single(input string name, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] t, input logic [31:0] exp_res, input logic exp_err);
    int n;
    rsp_ready = 1'b1;
    drive_req(m, a, b, t);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== LAT + 1 || rsp_res !== exp_res || rsp_tag !== t || rsp_err !== exp_err) begin
      errors++;
      $display("FAIL %s got cycle=%0d res=%h tag=%0d err=%b expected cycle=%0d res=%h tag=%0d err=%b",
               name, n, rsp_res, rsp_tag, rsp_err, LAT + 1, exp_res, t, exp_err);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic acc;
    rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive_req(2'b10, 32'h1000 + idx, 32'h2000_0000, idx[3:0]);
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    checks++;
    if (idx != 4 || req_ready !== 1'b0 || outstanding !== 3'd4) begin
      errors++;
      $display("FAIL backpressure_stall accepted=%0d req_ready=%b outstanding=%0d expected 4 0 4", idx, req_ready, outstanding);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      drive_req(2'b10, 32'h1000 + idx, 32'h2000_0000, idx[3:0]);
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    req_valid = 1'b0;
    for (int c = 0; c < 20 && outstanding != 0; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (idx != 6 || outstanding !== 3'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL backpressure_drain accepted=%0d outstanding=%0d pending=%0d expected 6 0 0", idx, outstanding, sb.size());
    end
  endtask

  task automatic test_reset_inflight();
    rsp_ready = 1'b1;
    drive_req(2'b00, 32'h1111_1111, 32'h2222_2222, 4'd9);
    @(posedge clk); #1;
    drive_req(2'b00, 32'h3333_3333, 32'h4444_4444, 4'd10);
    @(posedge clk); #1;
    req_valid = 1'b1;
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if ({rsp_valid, req_ready, fpu_d_trig, outstanding} !== '0) begin
      errors++;
      $display("FAIL reset_inflight rsp_valid=%b req_ready=%b trig=%b outstanding=%0d expected all 0",
               rsp_valid, req_ready, fpu_d_trig, outstanding);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (outstanding !== 3'd0 || rsp_valid !== 1'b0 || rsp_res !== 32'd0) begin
      errors++;
      $display("FAIL reset_stale outstanding=%0d rsp_valid=%b res=%h expected 0 0 0", outstanding, rsp_valid, rsp_res);
    end
  endtask

  task automatic test_back_to_back();
    int i = 0, nrsp = 0, first = -1, last = -1;
    logic acc;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (i < 16) drive_req(i[1:0], 32'hA000_0000 + i, 32'h0005_0000 + i, i[3:0]);
      else req_valid = 1'b0;
      @(negedge clk);
      acc = req_ready;
      if (i < 16) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready req=%0d got req_ready=%b expected 1", i, req_ready);
        end
      end
      if (rsp_valid) begin
        nrsp++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk); #1;
      if (i < 16 && acc) i++;
    end
    req_valid = 1'b0;
    checks++;
    if (nrsp != 16 || last - first != 15 || first != LAT + 1) begin
      errors++;
      $display("FAIL b2b_rate got rsps=%0d span=%0d first=%0d expected 16 15 %0d", nrsp, last - first, first, LAT + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single("add_1p2", 2'b00, 32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 1'b0);
    test_single("sub_3m1", 2'b01, 32'h4040_0000, 32'h3F80_0000, 4'd5, 32'h4000_0000, 1'b0);
    fpu_has_modes = 4'b0011;
    test_single("div_unsupported", 2'b11, 32'h4040_0000, 32'h3F80_0000, 4'd7, QNAN, 1'b1);
    fpu_has_modes = 4'hF;
    test_backpressure();
    test_reset_inflight();
    test_back_to_back();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL final_drain pending=%0d outstanding=%0d expected 0 0", sb.size(), outstanding);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
